// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode constants and sequencer state encodings shared by the sequencer files
package cpu_pkg;
  localparam logic [2:0] OP_HALT  = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_JUMP  = 3'd3;
  localparam logic [2:0] OP_ALU0  = 3'd4;
  localparam logic [2:0] OP_ALU1  = 3'd5;
  localparam logic [2:0] OP_ALU2  = 3'd6;
  localparam logic [2:0] OP_ALU3  = 3'd7;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEM       = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6
  } state_e;
endpackage

// File: rtl/wait_timer.sv
// wait_timer: 8-bit memory-wait counter with clear priority and a saturating expired flag
// Ports: clk, rst_n (async active-low); clr zeroes the count; en counts one wait cycle;
//        expired is high once the count has reached MAX.
module wait_timer #(
  parameter int unsigned MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt_q, cnt_d;
  always_comb begin
    expired = cnt_q >= 8'(MAX);
    cnt_d   = clr ? 8'd0 : (en && !expired) ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle instruction sequencer driving fetch, memory and datapath strobes
// Ports: clk, rst_n (async active-low); run enables execution; opcode/branch_taken from decoder/ALU;
//        imem_req/imem_ready and dmem_req/dmem_we/dmem_ready memory handshakes;
//        ir_load, pc_inc, pc_load, alu_start, rf_we single-cycle strobes; alu_op, rf_wsel datapath selects;
//        state_o, halted, error (sticky), retired (wrapping instruction count) status.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [2:0]  opcode,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        alu_start,
  output logic        rf_we,
  output logic [2:0]  alu_op,
  output logic        rf_wsel,
  output logic [2:0]  state_o,
  output logic        halted,
  output logic        error,
  output logic [15:0] retired
);
  state_e      state_q, state_d;
  logic        error_q, error_d;
  logic [15:0] retired_q, retired_d;
  logic        retire, expired, waiting;
  // A wait cycle is a cycle spent in FETCH/MEM without ready; the count
  // restarts on every state change so each handshake gets its own budget.
  // Once the count sits at WAIT_MAX, a ready in that cycle still completes.
  assign waiting = (state_q == FETCH && !imem_ready) || (state_q == MEM && !dmem_ready);
  wait_timer #(.MAX(WAIT_MAX)) u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_d != state_q),
    .en      (waiting),
    .expired (expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      error_q   <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      error_q   <= error_d;
      retired_q <= retired_d;
    end
  always_comb begin
    state_d = state_q;
    error_d = error_q;
    retire  = 1'b0;
    case (state_q)
      IDLE:      state_d = run ? FETCH : IDLE;
      FETCH:     if (imem_ready) state_d = DECODE;
                 else if (expired) begin
                   state_d = HALT;
                   error_d = 1'b1;
                 end
      DECODE:    state_d = (opcode == OP_HALT) ? HALT : EXECUTE;
      EXECUTE:   if (opcode[2]) state_d = WRITEBACK;
                 else if (opcode == OP_JUMP) retire = 1'b1;
                 else state_d = MEM;
      MEM:       if (dmem_ready) begin
                   if (opcode == OP_LOAD) state_d = WRITEBACK;
                   else retire = 1'b1;
                 end else if (expired) begin
                   state_d = HALT;
                   error_d = 1'b1;
                 end
      WRITEBACK: retire = 1'b1;
      default:   state_d = state_q;
    endcase
    if (retire) state_d = run ? FETCH : IDLE;
    retired_d = retired_q + 16'(retire);
  end
  always_comb begin
    imem_req  = state_q == FETCH;
    ir_load   = imem_req && imem_ready;
    pc_inc    = ir_load;
    alu_start = state_q == EXECUTE;
    alu_op    = alu_start ? opcode : 3'd0;
    pc_load   = alu_start && opcode == OP_JUMP && branch_taken;
    dmem_req  = state_q == MEM;
    dmem_we   = dmem_req && opcode == OP_STORE;
    rf_we     = state_q == WRITEBACK;
    rf_wsel   = rf_we && opcode == OP_LOAD;
    halted    = state_q == HALT;
    state_o   = state_q;
    error     = error_q;
    retired   = retired_q;
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized instruction-level check of cpu_sequencer against a timing/strobe model
module tb_cpu_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0;
  logic [2:0]  opcode = 3'd0;
  logic        branch_taken = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load, alu_start, rf_we, rf_wsel;
  logic        halted, error;
  logic [2:0]  alu_op, state_o;
  logic [15:0] retired;
  int          n_chk = 0;
  int          n_err = 0;
  int          exp_st;
  logic [15:0] exp_ret;
  logic        exp_err;

  cpu_sequencer #(.WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .alu_start(alu_start),
    .rf_we(rf_we), .alu_op(alu_op), .rf_wsel(rf_wsel), .state_o(state_o), .halted(halted),
    .error(error), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    chk("rst_out", {imem_req, ir_load, pc_inc, pc_load, alu_start, rf_we, rf_wsel, dmem_req, dmem_we,
                    alu_op, state_o, halted, error}, 0);
    chk("rst_ret", retired, 0);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_st = 0;
    exp_ret = 16'd0;
    exp_err = 1'b0;
    chk("idle_st", state_o, 0);
  endtask

  // Runs one instruction from FETCH (or IDLE) with a memory responder that
  // answers after wf / wm request cycles, then compares strobe tallies,
  // strobe positions and end state with what the instruction rules predict.
  task automatic run_instr(input logic [2:0] op, input logic bt, input int wf, input int wm, input int drop_at);
    int fc = 0, dc = 0, cyc, mw;
    int n_ir = 0, n_pci = 0, n_pcl = 0, n_alu = 0, n_rf = 0, n_dr = 0, n_dw = 0, n_ireq = 0;
    int alu_at = -1, rf_at = -1;
    logic [2:0] alu_seen = 3'd0;
    logic wsel_seen = 1'b0;
    logic err, merr, mem_op, halt_end, wb_op;
    if (exp_st == 0) begin
      run = 1'b1;
      @(posedge clk);
      #1;
      exp_st = 1;
    end
    run = 1'b1;
    opcode = op;
    branch_taken = bt;
    mem_op = op == 3'd1 || op == 3'd2;
    err = wf > 15;
    merr = !err && mem_op && wm > 15;
    mw = merr ? 16 : wm + 1;
    wb_op = op[2] || op == 3'd1;
    cyc = err ? 16 : wf + 2 + (op == 3'd0 ? 0 : op == 3'd3 ? 1 : op == 3'd2 ? 1 + mw :
                               op == 3'd1 ? 1 + mw + (merr ? 0 : 1) : 2);
    for (int c = 0; c < cyc; c++) begin
      @(negedge clk);
      imem_ready = imem_req && fc == wf;
      fc += int'(imem_req);
      dmem_ready = dmem_req && dc == wm;
      dc += int'(dmem_req);
      if (c == drop_at) run = 1'b0;
      #1;
      n_ir += int'(ir_load);
      n_pci += int'(pc_inc);
      n_pcl += int'(pc_load);
      n_dr += int'(dmem_req);
      n_dw += int'(dmem_we);
      n_ireq += int'(imem_req);
      if (alu_start) begin
        n_alu++;
        alu_at = c;
        alu_seen = alu_op;
      end
      if (rf_we) begin
        n_rf++;
        rf_at = c;
        wsel_seen = rf_wsel;
      end
    end
    @(posedge clk);
    #1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    halt_end = err || merr || op == 3'd0;
    if (!halt_end) exp_ret = exp_ret + 16'd1;
    exp_err = exp_err | err | merr;
    exp_st = halt_end ? 6 : run ? 1 : 0;
    chk("state", state_o, exp_st);
    chk("retired", retired, exp_ret);
    chk("error", error, exp_err);
    chk("halted", halted, exp_st == 6);
    chk("imem_req_cyc", n_ireq, err ? 16 : wf + 1);
    chk("ir_load", n_ir, !err);
    chk("pc_inc", n_pci, !err);
    chk("alu_start", n_alu, !err && op != 3'd0);
    if (!err && op != 3'd0) begin
      chk("alu_op", alu_seen, op);
      chk("alu_at", alu_at, wf + 2);
    end
    chk("pc_load", n_pcl, !err && op == 3'd3 && bt);
    chk("dmem_req_cyc", n_dr, (!err && mem_op) ? mw : 0);
    chk("dmem_we_cyc", n_dw, (!err && op == 3'd2) ? mw : 0);
    chk("rf_we", n_rf, !err && !merr && wb_op);
    if (!err && !merr && wb_op) begin
      chk("rf_wsel", wsel_seen, op == 3'd1);
      chk("rf_at", rf_at, op[2] ? wf + 3 : wf + 4 + wm);
    end
    if (halt_end) do_reset();
  endtask

  initial begin
    #2;
    do_reset();
    run_instr(3'd4, 1'b0, 0, 0, -1);
    chk("ret_first", retired, 16'd1);
    run_instr(3'd1, 1'b0, 0, 3, -1);
    run_instr(3'd3, 1'b1, 0, 0, -1);
    run_instr(3'd3, 1'b0, 0, 0, -1);
    run_instr(3'd2, 1'b0, 0, 0, -1);
    run_instr(3'd7, 1'b0, 16, 0, -1);
    run_instr(3'd5, 1'b0, 15, 0, -1);
    run_instr(3'd1, 1'b0, 1, 15, -1);
    run_instr(3'd2, 1'b0, 0, 16, -1);
    run_instr(3'd2, 1'b0, 0, 2, 4);
    run_instr(3'd6, 1'b0, 2, 0, 1);
    run_instr(3'd0, 1'b0, 0, 0, -1);
    run = 1'b1;
    opcode = 3'd2;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      imem_ready = c == 0;
      dmem_ready = 1'b0;
      #1;
    end
    chk("midmem_req", dmem_req, 1);
    chk("midmem_we", dmem_we, 1);
    do_reset();
    run_instr(3'd4, 1'b0, 0, 0, -1);
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    exp_ret = 16'hFFFF;
    chk("ret_preset", retired, 16'hFFFF);
    run_instr(3'd3, 1'b0, 0, 0, -1);
    chk("ret_wrap", retired, 16'h0000);
    for (int i = 0; i < 200; i++) begin
      logic [2:0] op;
      int wf, wm, dr;
      op = ($urandom_range(15, 0) == 0) ? 3'd0 : 3'($urandom_range(7, 1));
      wf = ($urandom_range(31, 0) == 0) ? 16 : $urandom_range(3, 0);
      wm = ($urandom_range(31, 0) == 0) ? 16 : $urandom_range(4, 0);
      dr = ($urandom_range(3, 0) == 0) ? $urandom_range(8, 0) : -1;
      run_instr(op, 1'($urandom_range(1, 0)), wf, wm, dr);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
